// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl: sweeps pos_nor over all 16 inputs into a truth table; `TRUTH_SWEEP_CHECK_EN adds expected-mask checking
module pos_nor (
  input  logic [3:0] abcd,
  output logic       f
);
  assign f = (abcd[2] & abcd[1]) | (abcd[1] & abcd[0]) | (abcd[3] & abcd[2] & abcd[0]);
endmodule

module truth_sweep_ctrl #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [4:0]  first_fail
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state;
  logic [7:0] hold;
  logic       f;
  logic       accept;
  logic       capture;

  pos_nor u_pos_nor (.abcd(abcd), .f(f));

  assign accept  = (state == IDLE) && start;
  assign capture = (state == RUN) && !abort && (hold == 8'(HOLD_CYCLES - 1));

  // sweep sequencer: steps abcd through 0..15 and records f into the table
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold        <= '0;
      abcd        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            abcd        <= '0;
            hold        <= '0;
            truth_table <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            abcd  <= '0;
          end else if (capture) begin
            hold              <= '0;
            truth_table[abcd] <= f;
            if (abcd == 4'd15) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              abcd  <= '0;
            end else begin
              abcd <= abcd + 4'd1;
            end
          end else begin
            hold <= hold + 8'd1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef TRUTH_SWEEP_CHECK_EN
  logic [15:0] exp_q;
  logic        miss;
  logic [4:0]  mm_next;

  assign miss    = f != exp_q[abcd];
  assign mm_next = mismatch_cnt + 5'(miss);

  // compare each captured bit against the latched mask; pass settles on the final capture
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q        <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= 5'd16;
    end else if (accept) begin
      exp_q        <= expected;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= 5'd16;
    end else if (capture) begin
      mismatch_cnt <= mm_next;
      if (miss && first_fail == 5'd16) first_fail <= {1'b0, abcd};
      if (abcd == 4'd15) pass <= mm_next == 5'd0;
    end
  end
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign pass            = 1'b0;
  assign mismatch_cnt    = 5'd0;
  assign first_fail      = 5'd16;
`endif
endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// tb_truth_sweep_ctrl: directed and randomized sweeps of truth_sweep_ctrl (HOLD_CYCLES 1 and 3) against a behavioural model
module tb_truth_sweep_ctrl;
  logic        clk = 1'b0, rst = 1'b1, st1 = 1'b0, st3 = 1'b0, abort = 1'b0;
  logic [15:0] expected = '0;
  logic [3:0]  a1, a3, o_abcd;
  logic        b1, b3, d1, d3, p1, p3, o_busy, o_done, o_pass;
  logic [15:0] t1, t3, o_tt;
  logic [4:0]  m1, m3, f1, f3, o_mm, o_ff;
  bit          sel3 = 1'b0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  truth_sweep_ctrl #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .abort(abort), .expected(expected),
    .abcd(a1), .busy(b1), .done(d1), .truth_table(t1), .pass(p1),
    .mismatch_cnt(m1), .first_fail(f1));

  truth_sweep_ctrl #(.HOLD_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .start(st3), .abort(abort), .expected(expected),
    .abcd(a3), .busy(b3), .done(d3), .truth_table(t3), .pass(p3),
    .mismatch_cnt(m3), .first_fail(f3));

  always_comb begin
    o_abcd = sel3 ? a3 : a1;
    o_busy = sel3 ? b3 : b1;
    o_done = sel3 ? d3 : d1;
    o_tt   = sel3 ? t3 : t1;
    o_pass = sel3 ? p3 : p1;
    o_mm   = sel3 ? m3 : m1;
    o_ff   = sel3 ? f3 : f1;
  end

  function automatic logic ref_f(input int i);
    logic a, b, c, d;
    a = i[3]; b = i[2]; c = i[1]; d = i[0];
    return (b && c) || (c && d) || (a && b && d);
  endfunction

  function automatic logic [15:0] ref_table(input int n);
    logic [15:0] t = '0;
    for (int i = 0; i < n; i++) t[i] = ref_f(i);
    return t;
  endfunction

  function automatic int first_diff(input logic [15:0] x);
    for (int i = 0; i < 16; i++) if (x[i]) return i;
    return 16;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_abcd"}, o_abcd, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_table"}, o_tt, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_mm"}, o_mm, 0);
    chk({tag, "_ff"}, o_ff, 16);
  endtask

  task automatic sweep(input int h, input logic [15:0] e, input int abort_cyc, input bit restart);
    int          n = 16;
    bit          hit = 1'b0;
    logic [15:0] tt, diff, mask;
    sel3     = (h == 3);
    expected = e;
    if (sel3) st3 = 1'b1; else st1 = 1'b1;
    step();
    st1 = 1'b0; st3 = 1'b0;
    for (int c = 1; c <= 16 * h; c++) begin
      chk("run_busy", o_busy, 1);
      chk("run_abcd", o_abcd, (c - 1) / h);
      if (restart && c == 3) begin
        if (sel3) st3 = 1'b1; else st1 = 1'b1;
      end
      if (c == abort_cyc) begin
        n     = (c - 1) / h;
        hit   = 1'b1;
        abort = 1'b1;
      end
      step();
      st1 = 1'b0; st3 = 1'b0; abort = 1'b0;
      if (hit) break;
    end
    tt   = ref_table(n);
    mask = 16'((32'd1 << n) - 1);
    diff = (tt ^ e) & mask;
    chk("end_done", o_done, hit ? 0 : 1);
    chk("end_busy", o_busy, 0);
    chk("end_abcd", o_abcd, 0);
    chk("end_table", o_tt, tt);
`ifdef TRUTH_SWEEP_CHECK_EN
    chk("end_pass", o_pass, (!hit && tt == e) ? 1 : 0);
    chk("end_mm", o_mm, $countones(diff));
    chk("end_ff", o_ff, first_diff(diff));
`else
    chk("end_pass", o_pass, 0);
    chk("end_mm", o_mm, 0);
    chk("end_ff", o_ff, 16);
`endif
    step();
    chk("post_done", o_done, 0);
    chk("post_table", o_tt, tt);
  endtask

  initial begin
    int h, ab;
    rst = 1'b1;
    step();
    step();
    chk_reset_vals("rst0");
    sel3 = 1'b1;
    chk_reset_vals("rst0_h3");
    rst = 1'b0;
    sweep(1, 16'hE8C8, 0, 1'b0);
    sweep(1, 16'hE8C9, 0, 1'b0);
    sweep(1, 16'h0000, 0, 1'b0);
    sweep(1, 16'hE8C8, 6, 1'b1);
    sel3     = 1'b0;
    expected = 16'hE8C8;
    st1      = 1'b1;
    step();
    st1 = 1'b0;
    repeat (8) step();
    chk("mid_busy", o_busy, 1);
    chk("mid_abcd", o_abcd, 8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("mid_rst");
    sweep(1, 16'hE8C8, 0, 1'b0);
    sweep(3, 16'hE8C8, 0, 1'b0);
    sweep(3, 16'hE8C8, 8, 1'b1);
    repeat (8) begin
      h  = ($urandom_range(0, 1) == 1) ? 3 : 1;
      ab = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 16 * h));
      sweep(h, 16'($urandom), ab, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/truth_sweep_ctrl.md
# truth_sweep_ctrl

Sequencer that drives the 4-input POS/NOR function block (`pos_nor`, f = B·C + C·D + A·B·D) through all 16 input combinations. It captures each output into a 16-bit truth-table register and, when compiled in, checks it against an expected mask. It sits between the lab's start/status controls and one internal `pos_nor` instance, and is the only driver of that instance's inputs.

## Interface
- `HOLD_CYCLES`, default 1: cycles each vector is held before f is sampled; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep; sampled only in IDLE.
- `abort`  in  1  ends a sweep early; sampled only in RUN.
- `expected`  in  16  expected truth table, bit i = f for {A,B,C,D} = i (A is MSB); latched when start is accepted.
- `abcd`  out  4  vector currently applied to `pos_nor` ({A,B,C,D}).
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a sweep completes normally.
- `table`  out  16  captured truth table.
- `pass`  out  1  table == latched expected; valid from the `done` cycle onward.
- `mismatch_cnt`  out  5  number of differing bits, 0..16.
- `first_fail`  out  5  lowest differing index 0..15, or 16 if there is none.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start = 1: latch expected, clear table/mismatch_cnt, set first_fail = 16, pass = 0, index = 0, hold counter = 0, go to RUN.
  - Otherwise stay in IDLE; results hold their last values.
- RUN:
  - abcd = index. The hold counter counts 0..HOLD_CYCLES-1.
  - At the edge where the counter equals HOLD_CYCLES-1: table[index] <= f. With check enabled: if f != expected[index], increment mismatch_cnt; if first_fail == 16, set first_fail = index. Then index += 1.
  - After index 15 is captured, go to DONE.
- DONE: done = 1 and pass is updated for one cycle, then go to IDLE.
- abort in RUN goes to IDLE at the next edge. Abort has priority over a capture on the same edge. No done pulse; pass stays 0; table keeps only the completed vectors.
- start while busy or in DONE is ignored. abort outside RUN is ignored.
- rst has priority over everything: state IDLE, abcd 0, busy 0, done 0, table 0, pass 0, mismatch_cnt 0, first_fail 16.
- The index is 4 bits, and the sweep ends on the index-15 capture. The index never wraps into a second pass.

## Timing
- start is high in cycle 0. RUN spans cycles 1..16·HOLD_CYCLES. done is high in cycle 16·HOLD_CYCLES+1. busy is high exactly during RUN.
- With HOLD_CYCLES = 1: abcd = k-1 in cycle k, and table[k-1] is written at the end of cycle k.
- f is combinational from abcd; it is sampled on the same edge, with no extra pipeline stage.
- table, pass, mismatch_cnt and first_fail are stable from the done cycle until the next accepted start or rst.
- abcd returns to 0 in IDLE.

## Configuration
- `TRUTH_SWEEP_CHECK_EN` defined:
  - expected is latched and compared.
  - pass, mismatch_cnt and first_fail behave as described above.
- Not defined:
  - No comparison logic is built, and expected is ignored.
  - pass = 0, mismatch_cnt = 0 and first_fail = 16 at all times.
  - Sweep, table, busy and done timing are unchanged.

## Test plan
- rst, then start with expected = 0xE8C8 and HOLD_CYCLES = 1 -> busy in cycles 1..16, done in cycle 17, table = 0xE8C8, pass = 1, mismatch_cnt = 0, first_fail = 16.
- expected = 0xE8C9 -> table = 0xE8C8, pass = 0, mismatch_cnt = 1, first_fail = 0. With expected = 0x0000 -> mismatch_cnt = 7, first_fail = 3.
- abort high in cycle 6 (abcd = 5) -> busy low in cycle 7, no done pulse, table = 0x0008. A second start pulse in cycle 3 of the same run has no effect.
- rst asserted in cycle 9 of a sweep -> next cycle all outputs at reset values (first_fail = 16); a new start then completes normally with table = 0xE8C8.
- HOLD_CYCLES = 3 -> each abcd value is held for 3 cycles, done in cycle 49, table = 0xE8C8.
- Built without TRUTH_SWEEP_CHECK_EN, expected = 0x0000 -> done in cycle 17, table = 0xE8C8, pass = 0, mismatch_cnt = 0, first_fail = 16.
